// File: rtl/pe_affine_cell.sv
// Registered affine-gap (Gotoh) systolic processing element: holds one query base and
// scores one DP row against a streamed reference, tracking the row maximum and its column.
module pe_affine_cell #(
   parameter int unsigned WIDTH    = 14,
   parameter int          GAP_OPEN = -12,
   parameter int          GAP_EXT  = -1,
   parameter int unsigned COL_W    = 10,
   parameter logic [127:0] SUB     = 128'h04FDFFFC_FD04FCFF_FFFC04FD_FCFFFD03
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_load,
   input  logic [1:0]              i_q_base,
   input  logic                    i_mode,
   input  logic                    i_start,
   input  logic signed [WIDTH-1:0] i_v_left_init,
   input  logic signed [WIDTH-1:0] i_i_left_init,
   input  logic signed [WIDTH-1:0] i_v_diag_init,
   input  logic                    i_valid,
   input  logic [1:0]              i_r_base,
   input  logic signed [WIDTH-1:0] i_v_top,
   input  logic signed [WIDTH-1:0] i_d_top,
   output logic                    o_valid,
   output logic [1:0]              o_r_base,
   output logic signed [WIDTH-1:0] o_v_score,
   output logic signed [WIDTH-1:0] o_d_score,
   output logic signed [WIDTH-1:0] o_i_score,
   output logic [1:0]              o_v_direct,
   output logic                    o_i_direct,
   output logic                    o_d_direct,
   output logic signed [WIDTH-1:0] o_max_score,
   output logic [COL_W-1:0]        o_max_col
);

   localparam int unsigned XW = WIDTH + 1;

   localparam logic signed [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH:0]   S_MIN_X = {2'b11, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH:0]   S_MAX_X = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH:0]   GO_X    = XW'(GAP_OPEN);
   localparam logic signed [WIDTH:0]   GE_X    = XW'(GAP_EXT);
   localparam logic [COL_W-1:0]        COL_MAX = {COL_W{1'b1}};

   localparam logic [1:0] DIR_DIAG = 2'd0;
   localparam logic [1:0] DIR_TOP  = 2'd1;
   localparam logic [1:0] DIR_LEFT = 2'd2;
   localparam logic [1:0] DIR_STOP = 2'd3;

   // Add at WIDTH+1 bits, then clamp into the WIDTH signed range.
   function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH:0]   b);
      logic signed [WIDTH:0]   s;
      logic signed [WIDTH-1:0] r;
      s = $signed({a[WIDTH-1], a}) + b;
      if (s > S_MAX_X)      r = S_MAX;
      else if (s < S_MIN_X) r = S_MIN;
      else                  r = s[WIDTH-1:0];
      return r;
   endfunction

   // Internal state
   logic [1:0]              q_base_q, q_base_d;
   logic                    mode_q, mode_d;
   logic signed [WIDTH-1:0] v_left_q, v_left_d;
   logic signed [WIDTH-1:0] i_left_q, i_left_d;
   logic signed [WIDTH-1:0] v_diag_q, v_diag_d;
   logic [COL_W-1:0]        col_q, col_d;

   // Output registers
   logic                    valid_q, valid_d;
   logic [1:0]              r_base_q, r_base_d;
   logic signed [WIDTH-1:0] v_score_q, v_score_d;
   logic signed [WIDTH-1:0] d_score_q, d_score_d;
   logic signed [WIDTH-1:0] i_score_q, i_score_d;
   logic [1:0]              v_dir_q, v_dir_d;
   logic                    i_dir_q, i_dir_d;
   logic                    d_dir_q, d_dir_d;
   logic signed [WIDTH-1:0] max_q, max_d;
   logic [COL_W-1:0]        max_col_q, max_col_d;

   // Working values for the current beat
   logic signed [7:0]       sub_tab [16];
   logic [3:0]              sub_idx;
   logic signed [WIDTH:0]   sub_x;
   logic                    cur_mode;
   logic signed [WIDTH-1:0] cur_v_left, cur_i_left, cur_v_diag, cur_max;
   logic [COL_W-1:0]        cur_col, cur_max_col;
   logic signed [WIDTH-1:0] vd, it1, it2, ival, dt1, dt2, dval, vsel;
   logic [1:0]              vdir;

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         sub_tab[k] = SUB[8*k +: 8];
      end
   end

   // Next-state: a start overrides the pass state before the same-cycle beat is scored.
   always_comb begin
      q_base_d  = q_base_q;
      mode_d    = mode_q;
      v_left_d  = v_left_q;
      i_left_d  = i_left_q;
      v_diag_d  = v_diag_q;
      col_d     = col_q;
      valid_d   = i_valid;
      r_base_d  = r_base_q;
      v_score_d = v_score_q;
      d_score_d = d_score_q;
      i_score_d = i_score_q;
      v_dir_d   = v_dir_q;
      i_dir_d   = i_dir_q;
      d_dir_d   = d_dir_q;
      max_d     = max_q;
      max_col_d = max_col_q;

      cur_mode    = i_start ? i_mode        : mode_q;
      cur_v_left  = i_start ? i_v_left_init : v_left_q;
      cur_i_left  = i_start ? i_i_left_init : i_left_q;
      cur_v_diag  = i_start ? i_v_diag_init : v_diag_q;
      cur_col     = i_start ? '0            : col_q;
      cur_max     = i_start ? (i_mode ? '0 : S_MIN) : max_q;
      cur_max_col = i_start ? '0            : max_col_q;

      sub_idx = {q_base_q, i_r_base};
      sub_x   = {{(WIDTH-7){sub_tab[sub_idx][7]}}, sub_tab[sub_idx]};
      vd      = sat_add(cur_v_diag, sub_x);
      it1     = sat_add(cur_i_left == cur_i_left ? cur_v_left : cur_v_left, GO_X);
      it2     = sat_add(cur_i_left, GE_X);
      ival    = (it1 > it2) ? it1 : it2;
      dt1     = sat_add(i_v_top, GO_X);
      dt2     = sat_add(i_d_top, GE_X);
      dval    = (dt1 > dt2) ? dt1 : dt2;

      if (vd >= ival && vd >= dval) begin
         vsel = vd;
         vdir = DIR_DIAG;
      end else if (ival >= dval) begin
         vsel = ival;
         vdir = DIR_LEFT;
      end else begin
         vsel = dval;
         vdir = DIR_TOP;
      end
      if (cur_mode && vsel[WIDTH-1]) begin
         vsel = '0;
         vdir = DIR_STOP;
      end

      if (i_load) q_base_d = i_q_base;

      if (i_start) begin
         mode_d    = cur_mode;
         v_left_d  = cur_v_left;
         i_left_d  = cur_i_left;
         v_diag_d  = cur_v_diag;
         col_d     = cur_col;
         max_d     = cur_max;
         max_col_d = cur_max_col;
      end

      if (i_valid) begin
         r_base_d  = i_r_base;
         v_score_d = vsel;
         d_score_d = dval;
         i_score_d = ival;
         v_dir_d   = vdir;
         i_dir_d   = (it1 > it2);
         d_dir_d   = (dt1 > dt2);
         v_left_d  = vsel;
         i_left_d  = ival;
         v_diag_d  = i_v_top;
         col_d     = (cur_col == COL_MAX) ? cur_col : cur_col + COL_W'(1);
         if (vsel > cur_max) begin
            max_d     = vsel;
            max_col_d = cur_col;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q_base_q  <= '0;
         mode_q    <= 1'b0;
         v_left_q  <= S_MIN;
         i_left_q  <= S_MIN;
         v_diag_q  <= '0;
         col_q     <= '0;
         valid_q   <= 1'b0;
         r_base_q  <= '0;
         v_score_q <= '0;
         d_score_q <= '0;
         i_score_q <= '0;
         v_dir_q   <= '0;
         i_dir_q   <= 1'b0;
         d_dir_q   <= 1'b0;
         max_q     <= '0;
         max_col_q <= '0;
      end else begin
         q_base_q  <= q_base_d;
         mode_q    <= mode_d;
         v_left_q  <= v_left_d;
         i_left_q  <= i_left_d;
         v_diag_q  <= v_diag_d;
         col_q     <= col_d;
         valid_q   <= valid_d;
         r_base_q  <= r_base_d;
         v_score_q <= v_score_d;
         d_score_q <= d_score_d;
         i_score_q <= i_score_d;
         v_dir_q   <= v_dir_d;
         i_dir_q   <= i_dir_d;
         d_dir_q   <= d_dir_d;
         max_q     <= max_d;
         max_col_q <= max_col_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_r_base    = r_base_q;
   assign o_v_score   = v_score_q;
   assign o_d_score   = d_score_q;
   assign o_i_score   = i_score_q;
   assign o_v_direct  = v_dir_q;
   assign o_i_direct  = i_dir_q;
   assign o_d_direct  = d_dir_q;
   assign o_max_score = max_q;
   assign o_max_col   = max_col_q;

endmodule

// File: tb/tb_pe_affine_cell.sv
// Bench for pe_affine_cell: directed test-plan scenarios plus random traffic, all checked
// against an integer-arithmetic model of the DP recurrence.
module tb_pe_affine_cell;

   localparam int unsigned WIDTH = 14;
   localparam int unsigned COL_W = 10;
   localparam int SMIN = -8192;
   localparam int SMAX = 8191;
   localparam int GO   = -12;
   localparam int GE   = -1;
   localparam int CMAX = 1023;

   logic                    i_clk, i_rst_n, i_load, i_mode, i_start, i_valid;
   logic [1:0]              i_q_base, i_r_base;
   logic signed [WIDTH-1:0] i_v_left_init, i_i_left_init, i_v_diag_init, i_v_top, i_d_top;
   logic                    o_valid, o_i_direct, o_d_direct;
   logic [1:0]              o_r_base, o_v_direct;
   logic signed [WIDTH-1:0] o_v_score, o_d_score, o_i_score, o_max_score;
   logic [COL_W-1:0]        o_max_col;

   pe_affine_cell dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load), .i_q_base(i_q_base),
      .i_mode(i_mode), .i_start(i_start), .i_v_left_init(i_v_left_init),
      .i_i_left_init(i_i_left_init), .i_v_diag_init(i_v_diag_init), .i_valid(i_valid),
      .i_r_base(i_r_base), .i_v_top(i_v_top), .i_d_top(i_d_top), .o_valid(o_valid),
      .o_r_base(o_r_base), .o_v_score(o_v_score), .o_d_score(o_d_score),
      .o_i_score(o_i_score), .o_v_direct(o_v_direct), .o_i_direct(o_i_direct),
      .o_d_direct(o_d_direct), .o_max_score(o_max_score), .o_max_col(o_max_col)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int passed = 0;
   int total  = 0;

   int sub_t [4][4] = '{'{3, -3, -1, -4}, '{-3, 4, -4, -1}, '{-1, -4, 4, -3}, '{-4, -1, -3, 4}};

   // Reference model state (plain integers)
   int m_q, m_mode, m_vl, m_il, m_vd, m_col;
   int e_valid, e_rb, e_v, e_d, e_i, e_vdir, e_idir, e_ddir, e_max, e_maxcol;

   function automatic int sat(input int x);
      return (x < SMIN) ? SMIN : ((x > SMAX) ? SMAX : x);
   endfunction

   function automatic int rnd_score();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return SMIN;
      if (r == 1) return SMAX;
      return int'($urandom_range(0, 600)) - 300;
   endfunction

   task automatic model_reset();
      m_q = 0; m_mode = 0; m_vl = SMIN; m_il = SMIN; m_vd = 0; m_col = 0;
      e_valid = 0; e_rb = 0; e_v = 0; e_d = 0; e_i = 0;
      e_vdir = 0; e_idir = 0; e_ddir = 0; e_max = 0; e_maxcol = 0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      int vd, it1, it2, iv, dt1, dt2, dv, v, dir;
      if (i_start) begin
         m_mode = int'(i_mode);
         m_vl = int'(i_v_left_init);
         m_il = int'(i_i_left_init);
         m_vd = int'(i_v_diag_init);
         m_col = 0;
         e_max = i_mode ? 0 : SMIN;
         e_maxcol = 0;
      end
      e_valid = int'(i_valid);
      if (i_valid) begin
         vd  = sat(m_vd + sub_t[m_q][int'(i_r_base)]);
         it1 = sat(m_vl + GO);
         it2 = sat(m_il + GE);
         iv  = (it1 > it2) ? it1 : it2;
         dt1 = sat(int'(i_v_top) + GO);
         dt2 = sat(int'(i_d_top) + GE);
         dv  = (dt1 > dt2) ? dt1 : dt2;
         if (vd >= iv && vd >= dv) begin v = vd; dir = 0; end
         else if (iv >= dv)        begin v = iv; dir = 2; end
         else                      begin v = dv; dir = 1; end
         if (m_mode == 1 && v < 0) begin v = 0; dir = 3; end
         e_rb = int'(i_r_base); e_v = v; e_d = dv; e_i = iv; e_vdir = dir;
         e_idir = (it1 > it2) ? 1 : 0;
         e_ddir = (dt1 > dt2) ? 1 : 0;
         m_vl = v; m_il = iv; m_vd = int'(i_v_top);
         if (v > e_max) begin e_max = v; e_maxcol = m_col; end
         if (m_col < CMAX) m_col++;
      end
      if (i_load) m_q = int'(i_q_base);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},  int'(o_valid),    e_valid);
      chk({tag, ".rbase"},  int'(o_r_base),   e_rb);
      chk({tag, ".v"},      int'(o_v_score),  e_v);
      chk({tag, ".d"},      int'(o_d_score),  e_d);
      chk({tag, ".i"},      int'(o_i_score),  e_i);
      chk({tag, ".vdir"},   int'(o_v_direct), e_vdir);
      chk({tag, ".idir"},   int'(o_i_direct), e_idir);
      chk({tag, ".ddir"},   int'(o_d_direct), e_ddir);
      chk({tag, ".max"},    int'(o_max_score), e_max);
      chk({tag, ".maxcol"}, int'(o_max_col),  e_maxcol);
   endtask

   task automatic drive(input bit load, input int qb, input bit mode, input bit start,
                        input int vli, input int ili, input int vdi,
                        input bit valid, input int rb, input int vtop, input int dtop);
      i_load = load; i_q_base = 2'(qb); i_mode = mode; i_start = start;
      i_v_left_init = WIDTH'(vli); i_i_left_init = WIDTH'(ili); i_v_diag_init = WIDTH'(vdi);
      i_valid = valid; i_r_base = 2'(rb); i_v_top = WIDTH'(vtop); i_d_top = WIDTH'(dtop);
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge i_clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      idle();
      model_reset();
      #3;
      check_all("reset");
      #9 i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      check_all("post_reset");

      // Local-mode match: V=3 diag, I=-12 open, D=-1 extend
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("load_a");
      drive(0, 0, 1, 1, 0, SMIN, 0, 1, 0, 0, 0); step("local_match");
      chk("lm.v", int'(o_v_score), 3);   chk("lm.vdir", int'(o_v_direct), 0);
      chk("lm.i", int'(o_i_score), -12); chk("lm.idir", int'(o_i_direct), 1);
      chk("lm.d", int'(o_d_score), -1);  chk("lm.ddir", int'(o_d_direct), 0);
      chk("lm.max", int'(o_max_score), 3); chk("lm.col", int'(o_max_col), 0);

      // Mismatch A/T clamped in local mode, diagonal in global mode
      drive(0, 0, 1, 1, 0, SMIN, 0, 1, 3, 0, -20); step("mm_local");
      chk("mml.v", int'(o_v_score), 0); chk("mml.vdir", int'(o_v_direct), 3);
      drive(0, 0, 0, 1, 0, SMIN, 0, 1, 3, 0, -20); step("mm_global");
      chk("mmg.v", int'(o_v_score), -4); chk("mmg.vdir", int'(o_v_direct), 0);
      chk("mmg.d", int'(o_d_score), -12); chk("mmg.ddir", int'(o_d_direct), 1);

      // Saturation at the signed minimum must not wrap
      drive(0, 0, 0, 1, SMIN, SMIN, SMIN, 1, 3, SMIN, SMIN); step("sat");
      chk("sat.v", int'(o_v_score), SMIN); chk("sat.i", int'(o_i_score), SMIN);
      chk("sat.vdir", int'(o_v_direct), 0);

      // Tie-breaking: diagonal wins a tie with I, left wins a tie with D
      drive(0, 0, 0, 1, 15, SMIN, 0, 1, 0, -100, -100); step("tie1");
      chk("tie1.v", int'(o_v_score), 3); chk("tie1.vdir", int'(o_v_direct), 0);
      drive(0, 0, 0, 1, 15, SMIN, -100, 1, 0, 15, -100); step("tie2");
      chk("tie2.v", int'(o_v_score), 3); chk("tie2.vdir", int'(o_v_direct), 2);

      // Streaming pass A,C,A,A in local mode with an idle gap, then restart with a beat
      drive(0, 0, 1, 1, 0, SMIN, 0, 0, 0, 0, 0); step("stream_start");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -20); step("stream0");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, -20); step("stream1");
      idle(); step("gap");
      chk("gap.valid", int'(o_valid), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -20); step("stream2");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, -20); step("stream3");
      drive(0, 0, 1, 1, 0, SMIN, 0, 1, 1, 0, -20); step("restart");
      chk("restart.col", int'(o_max_col), 0);

      // Column counter saturation: long low-score global pass, then one high beat
      drive(0, 0, 0, 1, SMIN, SMIN, SMIN, 0, 0, 0, 0); step("long_start");
      for (int n = 0; n < 1030; n++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 3, SMIN, SMIN);
         model_edge();
         @(posedge i_clk); #1;
      end
      check_all("long_tail");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 1000, SMIN); step("long_hi");
      chk("long.col", int'(o_max_col), CMAX);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0, rnd_score(), rnd_score(), rnd_score(),
               $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), rnd_score(), rnd_score());
         step("rand");
      end

      // Asynchronous reset mid-pass clears outputs before any clock edge
      drive(0, 0, 1, 1, 0, SMIN, 0, 1, 0, 0, 0); step("pre_rst");
      idle();
      #2 i_rst_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      #3 i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      check_all("after_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pe_affine_cell.md
Name: pe_affine_cell

Overview:
- Registered, parametrised affine-gap alignment processing element for the linear systolic array.
- Each instance holds one query base and scores one DP-matrix row as reference bases stream past, one base per valid beat.
- Compared with the earlier combinational cell, this block adds:
  - configurable width, gap penalties and substitution matrix;
  - global or local mode;
  - internal left/diagonal state;
  - per-row maximum-score and column tracking;
  - saturating arithmetic.

Parameters:
- WIDTH, 14: signed score width.
- GAP_OPEN, -12: signed gap-open penalty, added to V.
- GAP_EXT, -1: signed gap-extend penalty, added to I/D.
- COL_W, 10: column counter width.
- SUB, 128-bit packed: sixteen signed 8-bit scores.
  - Entry index = {query, ref}; entry k occupies bits [8k+7:8k].
  - Base encoding: A=0, C=1, G=2, T=3.
  - Default rows: A: 3,-3,-1,-4; C: -3,4,-4,-1; G: -1,-4,4,-3; T: -4,-1,-3,4.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_load, in, 1: capture i_q_base.
- i_q_base, in, 2: query base for this row.
- i_mode, in, 1: 0 = global, 1 = local. Sampled at i_start.
- i_start, in, 1: begin a new reference pass.
- i_v_left_init, in, WIDTH: V(row,0), sampled at i_start.
- i_i_left_init, in, WIDTH: I(row,0), sampled at i_start.
- i_v_diag_init, in, WIDTH: V(row-1,0), sampled at i_start.
- i_valid, in, 1: beat valid.
- i_r_base, in, 2: reference base.
- i_v_top, in, WIDTH: V from upstream PE for this column.
- i_d_top, in, WIDTH: D from upstream PE for this column.
- o_valid, out, 1: registered i_valid.
- o_r_base, out, 2: forwarded reference base.
- o_v_score, out, WIDTH: V for this cell.
- o_d_score, out, WIDTH: D for this cell.
- o_i_score, out, WIDTH: I for this cell.
- o_v_direct, out, 2: 0 = diagonal, 1 = top, 2 = left, 3 = local zero/stop.
- o_i_direct, out, 1: 1 = open (from V), 0 = extend.
- o_d_direct, out, 1: 1 = open (from V), 0 = extend.
- o_max_score, out, WIDTH: best V this pass.
- o_max_col, out, COL_W: column of o_max_score.

Behaviour:
- Reset (asynchronous assert on i_rst_n low):
  - All outputs and internal registers go to 0.
  - Exceptions: internal I_left and v_left go to the WIDTH signed minimum.
  - Mode resets to global.
- i_load: q_base <= i_q_base on the next edge. May occur mid-pass; it affects the next beat only.
- i_start:
  - Loads v_left, i_left and v_diag from the init ports and latches mode.
  - Clears the column counter to 0.
  - Clears o_max_score: to 0 in local mode, to the WIDTH signed minimum in global mode.
  - i_start with i_valid in the same cycle: start is applied first, and the beat is scored as column 0 using the init values.
- Per valid beat (scored from current state):
  - Vd = sat(v_diag + SUB[q, r])
  - It1 = sat(v_left + GAP_OPEN); It2 = sat(i_left + GAP_EXT); I = It1 > It2 ? It1 : It2; i_dir = (It1 > It2)
  - Dt1 = sat(i_v_top + GAP_OPEN); Dt2 = sat(i_d_top + GAP_EXT); D and d_dir use the same rule.
  - V selection:
    - Vd if Vd >= I and Vd >= D, direct 0;
    - else I if I >= D, direct 2;
    - else D, direct 1.
  - Local mode: if V < 0, V = 0 and direct = 3. I and D are not clamped.
  - sat() = two's-complement add at WIDTH+1 bits, clamped to the WIDTH signed range. It never wraps.
- Latency: exactly 1 cycle. Outputs register the result; o_valid = 1 for that cycle. Update state: v_left <= V, i_left <= I, v_diag <= i_v_top.
- Max tracking: if V > o_max_score (strict), update o_max_score and set o_max_col <= column counter. Ties keep the earliest column.
- Column counter: increments after each beat and saturates at all-ones (no wrap).
- i_valid low: o_valid = 0; all other outputs and state hold.
- Reset mid-pass: the pass is aborted immediately. A new i_start is required.

Test Plan:
- Local match: i_start with all inits 0, i_i_left_init = min, q=A; beat r=A, top V 0, top D 0 -> next cycle V=3 direct 0, I=-12 i_dir 1, D=-1 d_dir 0, max 3, col 0.
- Mismatch clamp: q=A, r=T, inits 0, i_v_top 0, i_d_top -20 -> local: V=0 direct 3. Global: V=-4 direct 0, D=-12 d_dir 1.
- Saturation, global mode: i_v_diag_init = -8192, r mismatch -4, left and top at -8192 -> V = -8192 (no wrap to positive); GAP_EXT on I_left = min stays min.
- Ties: v_left_init 15, diag 0, A/A, top V -100 -> Vd=3, I=3 -> direct 0. Then diag -100, v_left 15, i_v_top 15 -> I=D=3 -> direct 2.
- Streaming pass: r = A,C,A,A against q=A, local mode -> four 1-cycle-latency results; max/col track the strict improvement. Then i_start with i_valid -> col 0, max reflects only the new beat.
- Idle/reset: i_valid gaps hold outputs with o_valid 0. i_rst_n low mid-pass -> all outputs 0 in the same cycle, before any clock edge.
